// File: rtl/core_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - bus typedefs for instruction words and instruction addresses
//   - ZERO_WORD / INST_NOP constants
//   - fetch_state_e: fetch FSM encoding (BOOT / RUN / DRAIN)
package core_fetch_pkg;

  typedef logic [31:0] inst_byte_bus_t;
  typedef logic [31:0] inst_address_bus_t;

  localparam inst_byte_bus_t ZERO_WORD = 32'h0000_0000;
  // addi x0, x0, 0: the bubble shown to decode when nothing is buffered
  localparam inst_byte_bus_t INST_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO used twice by core_fetch (instruction buffer and
// in-order address queue).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   flush        empties the FIFO; push/pop are ignored in that cycle
//   push/push_data  write one entry
//   pop          drop the head entry (ignored when empty)
//   head_data    head entry, read combinationally from registered storage
//   count/empty/full  occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush && !empty;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage has no reset: head_data is only meaningful when !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words with their addresses and
// presents one instruction per cycle to decode.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   jump_flag_in, jump_addr_in     redirect from execute (addr bits [1:0] ignored)
//   hold_in                        pipeline stall, head instruction not consumed
//   fetch_req_out, fetch_addr_out  memory read request / word address
//   fetch_ack_in                   memory accepted the request this cycle
//   fetch_rvalid_in, fetch_rdata_in  in-order read data, >=1 cycle after ack
//   inst_out, inst_addr_out, inst_valid_out  instruction presented to decode
//   fetch_state_out                current fetch FSM state (debug)
//
// Memory handshake: a request transfers on a cycle where fetch_req_out and
// fetch_ack_in are both high; until then req stays high with a stable
// address (the PC only moves on a transfer, and req only drops on a redirect,
// which replaces the request anyway). Every transfer yields exactly one
// fetch_rvalid_in pulse later, in request order, with no back-pressure.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        hold_in,
  output logic        fetch_req_out,
  output logic [31:0] fetch_addr_out,
  input  logic        fetch_ack_in,
  input  logic        fetch_rvalid_in,
  input  logic [31:0] fetch_rdata_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out,
  output logic        inst_valid_out,
  output logic [1:0]  fetch_state_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state;
  inst_address_bus_t pc;
  logic [CW-1:0]     discard;

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     inst_count;
  logic              addr_empty;
  logic              addr_full;
  logic              inst_empty;
  logic              inst_full;
  logic [31:0]       rsp_addr;
  logic [63:0]       inst_head;

  logic [CW:0]       credit_used;
  logic              ack_fire;
  logic              rsp_accept;
  logic              inst_pop;
  logic [CW-1:0]     remaining;
  logic [CW-1:0]     discard_next;

  // The address queue holds exactly the requests still in flight in RUN, so
  // its occupancy doubles as the outstanding counter. A redirect flushes it;
  // responses still owed after that are tracked by 'discard' instead.
  assign credit_used   = {1'b0, outstanding} + {1'b0, inst_count};
  assign fetch_req_out = (state == FETCH_RUN) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH)) &&
                         !jump_flag_in;
  assign fetch_addr_out = pc;
  assign ack_fire       = fetch_req_out && fetch_ack_in;

  // A response is kept only in RUN and only when no redirect kills it.
  assign rsp_accept = (state == FETCH_RUN) && fetch_rvalid_in && !jump_flag_in;
  assign inst_pop   = !inst_empty && !hold_in && !jump_flag_in;

  // Responses still owed after a redirect in this cycle.
  assign remaining    = outstanding - CW'(fetch_rvalid_in);
  assign discard_next = discard - CW'(fetch_rvalid_in && (discard != '0));

  assign inst_valid_out  = !inst_empty;
  assign inst_out        = inst_empty ? NOP_INST  : inst_head[31:0];
  assign inst_addr_out   = inst_empty ? ZERO_WORD : inst_head[63:32];
  assign fetch_state_out = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH_BOOT;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      if (ack_fire) pc <= pc + 32'd4;
      // req is masked by jump_flag_in, so this never collides with ack_fire
      if (jump_flag_in) pc <= {jump_addr_in[31:2], 2'b00};

      case (state)
        FETCH_BOOT: state <= FETCH_RUN;
        FETCH_RUN: begin
          // If the only in-flight response returns in the redirect cycle
          // itself there is nothing left to drop, so fetch continues.
          if (jump_flag_in && (remaining != '0)) begin
            state   <= FETCH_DRAIN;
            discard <= remaining;
          end
        end
        FETCH_DRAIN: begin
          discard <= discard_next;
          if (discard_next == '0) state <= FETCH_RUN;
        end
        default: state <= FETCH_BOOT;
      endcase
    end
  end

  core_fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_flag_in),
    .push      (ack_fire),
    .push_data (pc),
    .pop       (rsp_accept),
    .head_data (rsp_addr),
    .count     (outstanding),
    .empty     (addr_empty),
    .full      (addr_full)
  );

  core_fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_flag_in),
    .push      (rsp_accept),
    .push_data ({rsp_addr, fetch_rdata_in}),
    .pop       (inst_pop),
    .head_data (inst_head),
    .count     (inst_count),
    .empty     (inst_empty),
    .full      (inst_full)
  );

  a_rsp_has_addr: assert property (@(posedge clk) disable iff (rst)
    !(rsp_accept && addr_empty));
  a_addr_q_room: assert property (@(posedge clk) disable iff (rst)
    !(ack_fire && addr_full));
  a_inst_q_room: assert property (@(posedge clk) disable iff (rst)
    !(rsp_accept && inst_full && !inst_pop));

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: random-latency in-order memory, randomized hold and
// redirect traffic, and a transaction-level reference model (queues of
// in-flight addresses and buffered instructions) checked every cycle.
module tb_core_fetch;
  import core_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        hold_in;
  logic        fetch_req_out;
  logic [31:0] fetch_addr_out;
  logic        fetch_ack_in;
  logic        fetch_rvalid_in;
  logic [31:0] fetch_rdata_in;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_valid_out;
  logic [1:0]  fetch_state_out;

  always #5 clk = ~clk;

  core_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_in    (jump_flag_in),
    .jump_addr_in    (jump_addr_in),
    .hold_in         (hold_in),
    .fetch_req_out   (fetch_req_out),
    .fetch_addr_out  (fetch_addr_out),
    .fetch_ack_in    (fetch_ack_in),
    .fetch_rvalid_in (fetch_rvalid_in),
    .fetch_rdata_in  (fetch_rdata_in),
    .inst_out        (inst_out),
    .inst_addr_out   (inst_addr_out),
    .inst_valid_out  (inst_valid_out),
    .fetch_state_out (fetch_state_out)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] inflight_q[$];   // accepted requests not yet answered
  int          m_stale;         // leading in-flight entries to be dropped
  logic [31:0] exp_addr_q[$];   // buffered instruction addresses
  logic [31:0] exp_inst_q[$];   // buffered instruction words

  // memory model
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc = 0;

  // stimulus knobs
  int ack_pct, hold_pct, jump_pm, lat_min, lat_max;

  // directed-check bookkeeping
  int          rcyc;
  int          first_req_cyc;
  logic [31:0] seen_q[$];
  bit          watch_first;
  logic [31:0] watch_addr;
  bit          wrap_watch;
  int          wrap_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc   = RESET_PC;
    m_stale = 0;
    inflight_q.delete();
    exp_addr_q.delete();
    exp_inst_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    wrap_watch  = 1'b0;
    watch_first = 1'b0;
    rcyc = 0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    cyc++;
    fetch_rvalid_in = 1'b0;
    if (mem_addr_q.size() > 0) begin
      if (mem_due_q[0] <= cyc) fetch_rvalid_in = 1'b1;
    end
    fetch_rdata_in = fetch_rvalid_in ? mem_word(mem_addr_q[0]) : 32'($urandom);
    fetch_ack_in   = int'($urandom_range(0, 99)) < ack_pct;
    hold_in        = int'($urandom_range(0, 99)) < hold_pct;
    jump_flag_in   = int'($urandom_range(0, 999)) < jump_pm;
    if ($urandom_range(0, 3) == 0)
      jump_addr_in = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else
      jump_addr_in = 32'($urandom);
  endtask

  // Compare this cycle's outputs with the model, then advance model and
  // memory to what the coming clock edge should produce.
  task automatic check_and_update();
    logic        exp_req;
    logic        exp_valid;
    logic [1:0]  exp_state;
    logic [31:0] a;
    @(negedge clk);
    rcyc++;
    exp_valid = exp_addr_q.size() > 0;
    exp_req   = !m_boot && (m_stale == 0) &&
                (inflight_q.size() + exp_addr_q.size() < DEPTH) && !jump_flag_in;
    exp_state = m_boot ? FETCH_BOOT : ((m_stale > 0) ? FETCH_DRAIN : FETCH_RUN);

    check("req",        32'(fetch_req_out),  32'(exp_req));
    check("fetch_addr", fetch_addr_out,      m_pc);
    check("inst_valid", 32'(inst_valid_out), 32'(exp_valid));
    check("inst",       inst_out,            exp_valid ? exp_inst_q[0] : NOP);
    check("inst_addr",  inst_addr_out,       exp_valid ? exp_addr_q[0] : 32'h0);
    check("state",      32'(fetch_state_out), 32'(exp_state));

    if (wrap_watch) begin
      check("pc_wrap", fetch_addr_out, 32'h0);
      wrap_hits++;
      wrap_watch = 1'b0;
    end
    if (fetch_req_out && fetch_ack_in && fetch_addr_out == 32'hFFFF_FFFC) wrap_watch = 1'b1;
    if (watch_first && inst_valid_out) begin
      check("first_after_redirect", inst_addr_out, watch_addr);
      watch_first = 1'b0;
    end
    if (fetch_req_out && first_req_cyc == 0) first_req_cyc = rcyc;
    if (inst_valid_out && !hold_in && !jump_flag_in && seen_q.size() < 3)
      seen_q.push_back(inst_addr_out);

    // memory
    if (fetch_rvalid_in) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (fetch_req_out && fetch_ack_in) begin
      mem_addr_q.push_back(fetch_addr_out);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end

    // reference model
    if (exp_valid && !hold_in && !jump_flag_in) begin
      void'(exp_addr_q.pop_front());
      void'(exp_inst_q.pop_front());
    end
    if (fetch_rvalid_in && inflight_q.size() > 0) begin
      a = inflight_q.pop_front();
      if (m_stale > 0) m_stale--;
      else if (!jump_flag_in) begin
        exp_addr_q.push_back(a);
        exp_inst_q.push_back(mem_word(a));
      end
    end
    if (exp_req && fetch_ack_in) begin
      inflight_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (jump_flag_in) begin
      exp_addr_q.delete();
      exp_inst_q.delete();
      m_stale = inflight_q.size();
      m_pc = {jump_addr_in[31:2], 2'b00};
    end
    m_boot = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      check_and_update();
      next_edge();
    end
  endtask

  // Redirect at a cycle with two requests in flight and no response arriving.
  task automatic arm_redirect(input logic [31:0] target, output bit done);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive();
      if (inflight_q.size() == 2 && !fetch_rvalid_in) begin
        jump_flag_in = 1'b1;
        jump_addr_in = target;
        done = 1'b1;
      end
      check_and_update();
      next_edge();
    end
  endtask

  // Called at a point shortly after a rising clock edge.
  task automatic apply_reset_async();
    jump_flag_in = 1'b0; jump_addr_in = 32'h0; hold_in = 1'b0;
    fetch_ack_in = 1'b0; fetch_rvalid_in = 1'b0; fetch_rdata_in = 32'h0;
    #1 rst = 1'b1;
    #1;
    check("rst_req",       32'(fetch_req_out),  32'h0);
    check("rst_fetch_addr", fetch_addr_out,     RESET_PC);
    check("rst_inst",      inst_out,            NOP);
    check("rst_inst_addr", inst_addr_out,       32'h0);
    check("rst_valid",     32'(inst_valid_out), 32'h0);
    check("rst_state",     32'(fetch_state_out), 32'(FETCH_BOOT));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    bit done;
    rst = 1'b0;
    ack_pct = 100; hold_pct = 0; jump_pm = 0; lat_min = 1; lat_max = 1;
    apply_reset_async();

    // straight-line flow, ack always, 1-cycle latency
    first_req_cyc = 0;
    seen_q.delete();
    run(12);
    check("first_req_cycle", 32'(first_req_cyc), 32'd2);
    for (int i = 0; i < 3; i++)
      check($sformatf("seq%0d", i), (i < seen_q.size()) ? seen_q[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // hold for five cycles
    begin
      logic [31:0] held_addr;
      hold_pct = 100;
      run(2);
      held_addr = inst_addr_out;
      run(3);
      check("hold_addr_stable", inst_addr_out, held_addr);
      check("hold_req_dropped", 32'(fetch_req_out), 32'h0);
      hold_pct = 0;
      run(10);
    end

    // redirect with two outstanding requests
    lat_min = 3; lat_max = 3;
    arm_redirect(32'h0000_0103, done);
    check("redirect_armed", 32'(done), 32'h1);
    check("drain_entered", 32'(fetch_state_out), 32'(FETCH_DRAIN));
    check("redirect_pc", fetch_addr_out, 32'h0000_0100);
    watch_first = 1'b1;
    watch_addr  = 32'h0000_0100;
    run(20);
    check("redirect_seen", 32'(watch_first), 32'h0);

    // redirect in the same cycle as a response, with hold
    lat_min = 1; lat_max = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive();
      if (fetch_rvalid_in) begin
        hold_in = 1'b1;
        jump_flag_in = 1'b1;
        jump_addr_in = 32'h0000_0200;
        done = 1'b1;
      end
      check_and_update();
      next_edge();
    end
    check("jr_armed", 32'(done), 32'h1);
    check("jr_valid", 32'(inst_valid_out), 32'h0);
    check("jr_nop",   inst_out, NOP);
    run(5);

    // PC wrap at the top of the address space
    wrap_hits = 0;
    ack_pct = 70; lat_min = 1; lat_max = 2;
    drive();
    jump_flag_in = 1'b1;
    jump_addr_in = 32'hFFFF_FFF6;
    check_and_update();
    next_edge();
    run(25);
    check("wrap_seen", 32'(wrap_hits > 0), 32'h1);

    // random traffic
    ack_pct = 75; hold_pct = 30; jump_pm = 40; lat_min = 1; lat_max = 4;
    run(1500);

    // asynchronous reset while draining
    ack_pct = 100; hold_pct = 0; jump_pm = 0; lat_min = 3; lat_max = 3;
    run(6);
    arm_redirect(32'h0000_0400, done);
    check("pre_reset_armed", 32'(done), 32'h1);
    check("pre_reset_drain", 32'(fetch_state_out), 32'(FETCH_DRAIN));
    apply_reset_async();
    lat_min = 1; lat_max = 1;
    first_req_cyc = 0;
    seen_q.delete();
    run(12);
    check("restart_first_req", 32'(first_req_cyc), 32'd2);
    check("restart_addr0", (seen_q.size() > 0) ? seen_q[0] : 32'hDEAD_BEEF, RESET_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Instruction fetch unit that generates the `inst`/`inst_addr` stream consumed by the decode stage.
- Owns the PC and issues in-order read requests to instruction memory over a req/ack + rvalid interface.
- Buffers returned words with their addresses and presents one instruction per cycle to decode.
- Handles hold from the pipeline and redirect (jump/branch) from execute, including discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of buffered instructions; also the maximum outstanding-plus-buffered credit (power of 2, ≥2).
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction is available.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- jump_flag_in  in  1  redirect request from execute
- jump_addr_in  in  32  redirect target; bits [1:0] ignored (treated as 0)
- hold_in  in  1  decode/execute stall; the current instruction is not consumed
- fetch_req_out  out  1  memory read request
- fetch_addr_out  out  32  request address, word aligned
- fetch_ack_in  in  1  memory accepted the request this cycle
- fetch_rvalid_in  in  1  read data valid; responses return in order, ≥1 cycle after ack
- fetch_rdata_in  in  32  read data
- inst_out  out  32  instruction to decode
- inst_addr_out  out  32  address of inst_out
- inst_valid_out  out  1  inst_out is a real fetched instruction

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = BOOT.
  - fetch_req_out = 0; fetch_addr_out = RESET_PC.
  - inst_out = NOP_INST; inst_addr_out = 0; inst_valid_out = 0.
- States:
  - BOOT → RUN after exactly one cycle. No request is issued in BOOT.
  - RUN: normal fetch.
  - DRAIN: entered on a redirect while outstanding > 0. It sets discard = outstanding, minus 1 if fetch_rvalid_in is high that cycle. No requests are issued. Each rvalid decrements discard. Return to RUN in the cycle after discard reaches 0.
  - A redirect with outstanding = 0 stays in / goes to RUN.
- Issue rule:
  - fetch_req_out = (state == RUN) && (outstanding + fifo_count < FIFO_DEPTH) && !jump_flag_in.
  - fetch_addr_out = pc.
  - On req && ack: pc += 4, wrapping 32'hFFFF_FFFC → 0; outstanding += 1.
  - req stays asserted with a stable address until ack.
- Response rule:
  - In RUN, an rvalid pushes {rdata, addr} into the FIFO and decrements outstanding. The address comes from a separate in-order address queue captured at ack.
  - Credit accounting guarantees the FIFO never overflows. An overflow is an assertion failure.
- Output:
  - FIFO head is shown combinationally from registered storage: inst_valid_out = !empty.
  - When empty: inst_out = NOP_INST, inst_addr_out = 0.
  - Pop when inst_valid_out && !hold_in.
  - There is no same-cycle bypass: response-to-decode latency is 1 cycle after rvalid.
- Redirect (jump_flag_in = 1), applied in the same cycle:
  - FIFO and address queue cleared; pc = {jump_addr_in[31:2], 2'b00}.
  - No pop and no push that cycle; an rvalid arriving in the same cycle is discarded.
  - Jump overrides hold_in.
  - A redirect during DRAIN reloads pc, and discard keeps counting the remaining responses.
- Simultaneous events:
  - Push and pop in the same cycle keep fifo_count unchanged.
  - ack and rvalid in the same cycle leave outstanding unchanged.
- Reset asserted mid-operation: everything returns to reset values immediately. In-flight memory responses after reset release are the memory's responsibility; memory is reset by the same rst.

Decomposition:
- Shared defines header holds:
  - `ZeroWord`, `InstByteBus`, `InstAddressBus`, `INST_NOP`.
  - Fetch state encodings FETCH_BOOT / FETCH_RUN / FETCH_DRAIN.
- Sub-module core_fetch_fifo: synchronous FIFO with parameterized width/depth, push/pop/flush, count/empty/full.
  - Instantiated twice: a 64-bit {addr, inst} buffer and a 32-bit address queue.

Test Plan:
- Reset, then a memory with ack=1 and fixed 1-cycle latency returning addr-derived data → first req in cycle 2 at 0x0; inst_valid_out rises with inst_addr_out = 0x0; then 0x4, 0x8 consecutively. Continuous flow requires FIFO_DEPTH ≥ 2.
- hold_in = 1 for 5 cycles with the FIFO filling → req drops once outstanding+count = 2; inst_addr_out stays constant; after release the sequence resumes with no gap or duplicate.
- jump_flag_in = 1, jump_addr_in = 0x0000_0103, with 2 outstanding → state DRAIN; two responses are dropped; next req addr = 0x0000_0100; first valid inst_addr_out = 0x100.
- Jump in the same cycle as rvalid and hold_in = 1 → that response is dropped, the FIFO is empty next cycle, and inst_out = 0x0000_0013.
- pc at 0xFFFF_FFFC is acked → next fetch_addr_out = 0x0000_0000.
- rst asserted asynchronously mid-DRAIN → outputs immediately at reset values; fetch restarts from RESET_PC after BOOT.
